vblank_commit_ctrl: RTL and testbench

- Avalon-MM slave that queues background-colour register writes in a small FIFO.
- Commits queued writes to the active colour registers only during vertical blanking, one entry per cycle, so no visible frame tears mid-scan.
- Sits between the bus and the VGA pixel path. It is clocked by the same 50 MHz clock as the VGA timing counters and consumes their hcount/vcount.
- An immediate mode lets software drain writes at any time.

---
 rtl/vga_intf_pkg.sv | 22 ++
 rtl/reg_write_fifo.sv | 51 +++++
 rtl/vblank_commit_ctrl.sv | 110 +++++++++++
 tb/tb_vblank_commit_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_intf_pkg.sv
// vga_intf_pkg: VGA timing constants and colour-commit types shared by
// the VGA counters and the background-colour commit controller.
package vga_intf_pkg;
    localparam int HTOTAL  = 800;
    localparam int VACTIVE = 480;
    localparam int VTOTAL  = 525;

    typedef enum logic [2:0] {
        REG_R    = 3'd0,
        REG_G    = 3'd1,
        REG_B    = 3'd2,
        REG_CTRL = 3'd3,
        REG_STAT = 3'd4
    } reg_addr_e;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DRAIN} commit_state_e;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
    } cmd_t;
endpackage

// File: rtl/reg_write_fifo.sv
// reg_write_fifo: synchronous FIFO of colour-register commands with
// flush and occupancy level.
module reg_write_fifo
    import vga_intf_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_push,
    input  cmd_t                     i_din,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output cmd_t                     o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    cmd_t            r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [LW-1:0]   r_level;
    logic            w_push;
    logic            w_pop;

    assign o_full  = r_level == LW'(DEPTH);
    assign o_empty = r_level == '0;
    assign o_level = r_level;
    assign o_dout  = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_din;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            r_wptr  <= r_wptr + AW'(w_push);
            r_rptr  <= r_rptr + AW'(w_pop);
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
        end
    end
endmodule

// File: rtl/vblank_commit_ctrl.sv
// vblank_commit_ctrl: Avalon-MM slave that queues background-colour writes
// and commits them to the active registers only during vertical blanking.
module vblank_commit_ctrl
    import vga_intf_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int VACTIVE = vga_intf_pkg::VACTIVE
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic [7:0]   i_writedata,
    input  logic         i_write,
    input  logic         i_read,
    input  logic         i_chipselect,
    input  logic [2:0]   i_address,
    output logic [7:0]   o_readdata,
    output logic         o_waitrequest,
    input  logic [10:0]  i_hcount,
    input  logic [9:0]   i_vcount,
    output logic [7:0]   o_bg_r,
    output logic [7:0]   o_bg_g,
    output logic [7:0]   o_bg_b,
    output logic         o_frame_tick
);
    commit_state_e          r_state;
    logic                   r_ctrl;
    logic [7:0]             r_bg_r;
    logic [7:0]             r_bg_g;
    logic [7:0]             r_bg_b;
    logic                   r_tick;
    logic [7:0]             r_readdata;

    cmd_t                   w_head;
    logic                   w_full;
    logic                   w_empty;
    logic [$clog2(DEPTH):0] w_level;
    logic [3:0]             w_level4;
    logic                   w_acc;
    logic                   w_push;
    logic                   w_flush;
    logic                   w_pop;
    logic                   w_last;
    logic                   w_window;
    logic                   w_busy;
    logic [7:0]             w_rdata;
    commit_state_e          w_next;
    logic                   w_unused;

    assign w_unused  = ^i_hcount;
    assign w_level4  = 4'(w_level);
    assign w_acc     = i_chipselect && i_write && !w_full;
    assign w_push    = w_acc && i_address < REG_CTRL;
    assign w_flush   = w_acc && i_address == REG_STAT && i_writedata[0];
    assign w_window  = r_ctrl || i_vcount >= 10'(VACTIVE);
    assign w_pop     = r_state == ST_DRAIN && !w_empty;
    assign w_last    = w_level4 <= 4'd1 && !w_push;
    assign w_busy    = r_state != ST_IDLE;

    reg_write_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_push    (w_push),
        .i_din     ('{idx: i_address[1:0], data: i_writedata}),
        .i_pop     (w_pop),
        .i_flush   (w_flush),
        .o_dout    (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (w_level)
    );

    always_comb begin
        w_next = r_state == ST_IDLE ? (w_empty ? ST_IDLE : (w_window ? ST_DRAIN : ST_WAIT)) :
                 r_state == ST_WAIT ? (w_window ? ST_DRAIN : ST_WAIT) :
                 w_last ? ST_IDLE : (w_window ? ST_DRAIN : ST_WAIT);
        w_rdata = i_address == REG_R    ? r_bg_r :
                  i_address == REG_G    ? r_bg_g :
                  i_address == REG_B    ? r_bg_b :
                  i_address == REG_CTRL ? {7'b0, r_ctrl} :
                  i_address == REG_STAT ? {w_busy, 3'b0, w_level4} : 8'h00;
    end

    // A flush abandons any drain in progress without announcing a frame tick.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state    <= ST_IDLE;
            r_ctrl     <= 1'b0;
            r_bg_r     <= 8'h00;
            r_bg_g     <= 8'h00;
            r_bg_b     <= 8'h80;
            r_tick     <= 1'b0;
            r_readdata <= 8'h00;
        end else begin
            r_state    <= w_flush ? ST_IDLE : w_next;
            r_ctrl     <= (w_acc && i_address == REG_CTRL) ? i_writedata[0] : r_ctrl;
            r_bg_r     <= (w_pop && {1'b0, w_head.idx} == REG_R) ? w_head.data : r_bg_r;
            r_bg_g     <= (w_pop && {1'b0, w_head.idx} == REG_G) ? w_head.data : r_bg_g;
            r_bg_b     <= (w_pop && {1'b0, w_head.idx} == REG_B) ? w_head.data : r_bg_b;
            r_tick     <= w_pop && w_last && !w_flush;
            r_readdata <= (i_chipselect && i_read) ? w_rdata : r_readdata;
        end
    end

    assign o_readdata    = r_readdata;
    assign o_waitrequest = w_full;
    assign o_bg_r        = r_bg_r;
    assign o_bg_g        = r_bg_g;
    assign o_bg_b        = r_bg_b;
    assign o_frame_tick  = r_tick;
endmodule

// File: tb/tb_vblank_commit_ctrl.sv
// tb_vblank_commit_ctrl: directed vectors with hand-computed expectations
// for the blanking-synchronised colour commit controller.
module tb_vblank_commit_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  wd = 8'h00;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic        cs = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic [7:0]  rdata;
    logic        waitreq;
    logic [10:0] hcount = 11'd0;
    logic [9:0]  vcount = 10'd100;
    logic [7:0]  bg_r, bg_g, bg_b;
    logic        ftick;
    int          n_total = 0;
    int          n_bad = 0;
    int          n_ticks;
    logic [7:0]  rv;

    vblank_commit_ctrl dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_writedata   (wd),
        .i_write       (wr),
        .i_read        (rd),
        .i_chipselect  (cs),
        .i_address     (addr),
        .o_readdata    (rdata),
        .o_waitrequest (waitreq),
        .i_hcount      (hcount),
        .i_vcount      (vcount),
        .o_bg_r        (bg_r),
        .o_bg_g        (bg_g),
        .o_bg_b        (bg_b),
        .o_frame_tick  (ftick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) hcount <= (hcount == 11'd799) ? 11'd0 : hcount + 11'd1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; wd = d;
        tick();
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [7:0] d);
        cs = 1'b1; rd = 1'b1; addr = a;
        tick();
        cs = 1'b0; rd = 1'b0;
        d = rdata;
    endtask

    task automatic chk_colours(input string tag, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        chk({tag, "_r"}, bg_r, r);
        chk({tag, "_g"}, bg_g, g);
        chk({tag, "_b"}, bg_b, b);
    endtask

    initial begin
        // Reset and basic blanking commit
        tick(); tick();
        rst_n = 1'b1;
        chk_colours("rst", 8'h00, 8'h00, 8'h80);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_tick", ftick, 1'b0);
        chk("rst_wait", waitreq, 1'b0);
        bus_wr(3'd0, 8'h12);
        bus_wr(3'd1, 8'h34);
        bus_wr(3'd2, 8'h56);
        bus_rd(3'd4, rv);
        chk("q3_stat", rv, 8'h83);
        chk_colours("q3", 8'h00, 8'h00, 8'h80);
        vcount = 10'd480;
        tick();
        chk("enter_drain_r", bg_r, 8'h00);
        tick();
        chk_colours("pop1", 8'h12, 8'h00, 8'h80);
        tick();
        chk_colours("pop2", 8'h12, 8'h34, 8'h80);
        chk("pop2_tick", ftick, 1'b0);
        tick();
        chk_colours("pop3", 8'h12, 8'h34, 8'h56);
        chk("pop3_tick", ftick, 1'b1);
        tick();
        chk("tick_once", ftick, 1'b0);
        bus_rd(3'd4, rv);
        chk("drained_stat", rv, 8'h00);

        // Fill to full, stall the ninth write until the first pop frees a slot
        vcount = 10'd200;
        for (int i = 0; i < 8; i++) bus_wr(3'(i % 3), 8'hA0 + 8'(i));
        chk("full_wait", waitreq, 1'b1);
        cs = 1'b1; wr = 1'b1; addr = 3'd0; wd = 8'hEE;
        tick();
        chk("stall_wait", waitreq, 1'b1);
        vcount = 10'd480;
        tick();
        chk("stall_drain_wait", waitreq, 1'b1);
        tick();
        chk("first_pop_wait", waitreq, 1'b0);
        chk("first_pop_r", bg_r, 8'hA0);
        tick();
        cs = 1'b0; wr = 1'b0;
        n_ticks = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ftick) n_ticks++;
        end
        chk("full_ticks", n_ticks, 1);
        chk_colours("full_final", 8'hEE, 8'hA7, 8'hA5);
        bus_rd(3'd4, rv);
        chk("full_stat", rv, 8'h00);

        // Blanking ends mid-drain: remainder waits for the next interval
        vcount = 10'd200;
        bus_wr(3'd0, 8'h11);
        bus_wr(3'd1, 8'h22);
        bus_wr(3'd2, 8'h33);
        bus_wr(3'd0, 8'h44);
        vcount = 10'd524;
        tick(); tick();
        vcount = 10'd0;
        tick(); tick(); tick();
        bus_rd(3'd4, rv);
        chk("split_stat", rv, 8'h82);
        chk_colours("split", 8'h11, 8'h22, 8'hA5);
        vcount = 10'd480;
        tick(); tick();
        chk("split_b", bg_b, 8'h33);
        tick();
        chk("split_r", bg_r, 8'h44);
        chk("split_tick", ftick, 1'b1);

        // Immediate mode commits outside blanking
        vcount = 10'd10;
        bus_wr(3'd3, 8'h01);
        bus_wr(3'd2, 8'hAA);
        chk("imm_before", bg_b, 8'h33);
        tick(); tick();
        chk("imm_b", bg_b, 8'hAA);
        bus_rd(3'd3, rv);
        chk("imm_ctrl", rv, 8'h01);
        bus_wr(3'd3, 8'h00);
        bus_rd(3'd3, rv);
        chk("ctrl_off", rv, 8'h00);

        // Flush discards queued entries silently
        bus_wr(3'd0, 8'h55);
        bus_wr(3'd1, 8'h66);
        bus_wr(3'd2, 8'h77);
        bus_rd(3'd4, rv);
        chk("preflush_stat", rv, 8'h83);
        bus_wr(3'd4, 8'h01);
        bus_rd(3'd4, rv);
        chk("flush_stat", rv, 8'h00);
        vcount = 10'd480;
        n_ticks = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ftick) n_ticks++;
        end
        chk("flush_ticks", n_ticks, 0);
        chk_colours("flush", 8'h44, 8'h22, 8'hAA);
        bus_rd(3'd5, rv);
        chk("rd_addr5", rv, 8'h00);

        // Reset in the middle of a drain
        vcount = 10'd10;
        bus_wr(3'd0, 8'h01);
        bus_wr(3'd1, 8'h02);
        bus_wr(3'd2, 8'h03);
        vcount = 10'd480;
        tick(); tick();
        chk("mid_drain_r", bg_r, 8'h01);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_colours("mid_rst", 8'h00, 8'h00, 8'h80);
        chk("mid_rst_rdata", rdata, 8'h00);
        chk("mid_rst_tick", ftick, 1'b0);
        chk("mid_rst_wait", waitreq, 1'b0);
        bus_rd(3'd4, rv);
        chk("mid_rst_stat", rv, 8'h00);
        tick(); tick(); tick();
        chk_colours("post_rst", 8'h00, 8'h00, 8'h80);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
